// File: rtl/stream_packetizer_if.sv
// Stream handshake bundle (data, valid, last, ready).
// The master drives data/valid/last; the slave drives ready.
interface stream_packetizer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_packetizer.sv
// Buffers a 32-bit sample stream and slices it into packets for the MAC.
// Optional header {HDR_MAGIC, seqNum}; upstream tlast closes a packet early.
module stream_packetizer #(
    parameter int          DEPTH_LOG2 = 9,
    parameter logic [15:0] HDR_MAGIC  = 16'hA5A5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [15:0]             packetSize,
    input  logic                    hdrEn,
    stream_packetizer_if.slave      s_axis,
    stream_packetizer_if.master     m_axis,
    output logic [15:0]             seqNum,
    output logic [DEPTH_LOG2:0]     fifoLevel
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] DEPTH_U = DEPTH;
    localparam logic [DEPTH_LOG2:0] FULL = DEPTH_U[DEPTH_LOG2:0];

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DEPTH_LOG2:0]   pend_q, pend_d;
    logic [DEPTH_LOG2:0]   plen_q, plen_d;
    logic [DEPTH_LOG2:0]   idx_q, idx_d;
    logic [15:0]           seq_q, seq_d;

    logic [32:0]           mem [DEPTH];
    logic [32:0]           head;
    logic                  push, pop;
    logic                  s_ready;
    logic [DEPTH_LOG2:0]   p_cur;
    logic [31:0]           p_ext;
    logic                  tvalid_c, tlast_c;
    logic [31:0]           tdata_c;

    assign head    = mem[rd_ptr_q];
    assign s_ready = !reset && (level_q != FULL);
    assign push    = s_axis.tvalid && s_ready;

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = reset ? 1'b0 : tvalid_c;
    assign m_axis.tlast  = reset ? 1'b0 : tlast_c;
    assign m_axis.tdata  = reset ? 32'd0 : tdata_c;
    assign seqNum        = seq_q;
    assign fifoLevel     = level_q;

    // Packet length in words, clamped to 1..DEPTH
    always_comb begin
        p_ext = {18'd0, packetSize[15:2]};
        p_cur = p_ext[DEPTH_LOG2:0];
        if (p_ext == 32'd0) begin
            p_cur = 1;
        end else if (p_ext > DEPTH_U) begin
            p_cur = FULL;
        end
    end

    // Packet FSM: next state, stream outputs and pop request
    always_comb begin
        state_d  = state_q;
        plen_d   = plen_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        pop      = 1'b0;
        tvalid_c = 1'b0;
        tlast_c  = 1'b0;
        tdata_c  = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (en && (level_q >= p_cur || pend_q != '0)) begin
                    plen_d  = p_cur;
                    idx_d   = '0;
                    state_d = hdrEn ? HDR : DATA;
                end
            end
            HDR: begin
                tvalid_c = 1'b1;
                tdata_c  = {HDR_MAGIC, seq_q};
                if (m_axis.tready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tvalid_c = 1'b1;
                tdata_c  = head[31:0];
                tlast_c  = (idx_q == plen_q - 1'b1) || head[32];
                if (m_axis.tready) begin
                    pop   = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (tlast_c) begin
                        seq_d   = seq_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, fill level and count of buffered tlast flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        pend_d   = pend_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        if ((push && s_axis.tlast) && !(pop && head[32])) begin
            pend_d = pend_q + 1'b1;
        end else if (!(push && s_axis.tlast) && (pop && head[32])) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // FIFO storage write, tlast flag kept alongside the data
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pend_q   <= '0;
            plen_q   <= '0;
            idx_q    <= '0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pend_q   <= pend_d;
            plen_q   <= plen_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
        end
    end
endmodule

// File: tb/tb_stream_packetizer.sv
// Scoreboard bench for stream_packetizer (FIFO depth 16).
// Directed vectors queue expected words; a negedge monitor checks them.
module tb_stream_packetizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] packetSize = 16'd16;
    logic        hdrEn = 1'b0;
    logic [15:0] seqNum;
    logic [4:0]  fifoLevel;

    stream_packetizer_if s_if ();
    stream_packetizer_if m_if ();

    stream_packetizer #(.DEPTH_LOG2(4), .HDR_MAGIC(16'hA5A5)) dut (
        .clk        (clk),
        .reset      (rst),
        .en         (en),
        .packetSize (packetSize),
        .hdrEn      (hdrEn),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .seqNum     (seqNum),
        .fifoLevel  (fifoLevel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];
    logic [15:0] exp_seq = 16'd0;
    logic        bp_run;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = s_if.tready;
            step();
            n++;
        end
        s_if.tvalid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no accept expected accept of %h", d);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words left expected 0", name,
                     exp_q.size());
        end
        repeat (3) step();
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!m_if.tvalid || m_if.tdata !== prev_data ||
                    m_if.tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got v%b %h l%b expected v1 %h l%b",
                             m_if.tvalid, m_if.tdata, m_if.tlast, prev_data, prev_last);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h l%b expected nothing",
                             m_if.tdata, m_if.tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_if.tlast, m_if.tdata} !== e) begin
                        errors++;
                        $display("FAIL out_word: got %h l%b expected %h l%b",
                                 m_if.tdata, m_if.tlast, e[31:0], e[32]);
                    end
                end
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
        end
    end

    initial begin
        int acc_cnt;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'd0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst_m_tlast", {31'd0, m_if.tlast}, 32'd0);
        chk("rst_m_tdata", m_if.tdata, 32'd0);
        chk("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_seq", {16'd0, seqNum}, 32'd0);
        chk("rst_level", {27'd0, fifoLevel}, 32'd0);

        // Full-size packets with header
        en = 1'b1;
        hdrEn = 1'b1;
        packetSize = 16'd16;
        expect_word(32'hA5A50000, 1'b0);
        for (int i = 0; i < 4; i++) expect_word(i, i == 3);
        expect_word(32'hA5A50001, 1'b0);
        for (int i = 4; i < 8; i++) expect_word(i, i == 7);
        for (int i = 0; i < 8; i++) push_word(i, 1'b0);
        wait_drain("hdr");
        exp_seq = 16'd2;
        chk("hdr_seq", {16'd0, seqNum}, {16'd0, exp_seq});

        // Short packet closed by upstream tlast
        hdrEn = 1'b0;
        expect_word(32'd10, 1'b0);
        expect_word(32'd11, 1'b0);
        expect_word(32'd12, 1'b1);
        push_word(32'd10, 1'b0);
        push_word(32'd11, 1'b0);
        push_word(32'd12, 1'b1);
        wait_drain("short");
        exp_seq = 16'd3;
        chk("short_seq", {16'd0, seqNum}, {16'd0, exp_seq});
        chk("short_pend", 32'(dut.pend_q), 32'd0);

        // Random backpressure, 62 packets of 16 words
        packetSize = 16'd64;
        for (int i = 0; i < 992; i++) expect_word(32'h1000 + i, (i % 16) == 15);
        bp_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 992; i++) push_word(32'h1000 + i, 1'b0);
                wait_drain("bp");
                bp_run = 1'b0;
            end
            begin
                while (bp_run) begin
                    m_if.tready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        m_if.tready = 1'b1;
        repeat (3) step();
        exp_seq = 16'd65;
        chk("bp_seq", {16'd0, seqNum}, {16'd0, exp_seq});
        chk("bp_level", {27'd0, fifoLevel}, 32'd0);

        // FIFO full with packetSize clamped to 16
        m_if.tready = 1'b0;
        packetSize = 16'd256;
        for (int i = 0; i < 16; i++) expect_word(32'd100 + i, i == 15);
        acc_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'd100 + acc_cnt;
            s_if.tlast  = 1'b0;
            @(negedge clk);
            if (s_if.tready) acc_cnt++;
            step();
        end
        s_if.tvalid = 1'b0;
        chk("full_accepted", acc_cnt, 32'd16);
        chk("full_level", {27'd0, fifoLevel}, 32'd16);
        chk("full_s_tready", {31'd0, s_if.tready}, 32'd0);
        m_if.tready = 1'b1;
        wait_drain("full");
        chk("full_s_tready_back", {31'd0, s_if.tready}, 32'd1);
        chk("full_level_empty", {27'd0, fifoLevel}, 32'd0);
        for (int i = 16; i < 20; i++) expect_word(32'd100 + i, i == 19);
        for (int i = 16; i < 20; i++) push_word(32'd100 + i, i == 19);
        wait_drain("full_tail");
        exp_seq = 16'd67;
        chk("full_seq", {16'd0, seqNum}, {16'd0, exp_seq});

        // Zero packet size; en=0 holds words in the FIFO
        en = 1'b0;
        packetSize = 16'd0;
        for (int i = 0; i < 3; i++) push_word(32'd200 + i, 1'b0);
        repeat (5) step();
        chk("en0_level", {27'd0, fifoLevel}, 32'd3);
        chk("en0_seq", {16'd0, seqNum}, {16'd0, exp_seq});
        for (int i = 0; i < 3; i++) expect_word(32'd200 + i, 1'b1);
        en = 1'b1;
        wait_drain("p1");
        exp_seq = 16'd70;
        chk("p1_seq", {16'd0, seqNum}, {16'd0, exp_seq});

        // Reset during DATA at word index 2
        packetSize = 16'd16;
        m_if.tready = 1'b0;
        expect_word(32'd50, 1'b0);
        expect_word(32'd51, 1'b0);
        for (int i = 0; i < 4; i++) push_word(32'd50 + i, 1'b0);
        for (int n = 0; n < 50 && !m_if.tvalid; n++) @(negedge clk);
        chk("mid_tvalid_seen", {31'd0, m_if.tvalid}, 32'd1);
        step();
        m_if.tready = 1'b1;
        step();
        step();
        m_if.tready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_after_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("mid_after_level", {27'd0, fifoLevel}, 32'd0);
        chk("mid_after_seq", {16'd0, seqNum}, 32'd0);
        chk("mid_after_state", 32'(dut.state_q), 32'd0);
        chk("mid_words_sent", exp_q.size(), 32'd0);
        step();
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) expect_word(32'd60 + i, i == 3);
        for (int i = 0; i < 4; i++) push_word(32'd60 + i, 1'b0);
        wait_drain("post_rst");
        exp_seq = 16'd1;
        chk("post_rst_seq", {16'd0, seqNum}, {16'd0, exp_seq});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
